// File: rtl/dbg_dut_responder.sv
// DUT-side debug endpoint: decodes debugger commands and drives the core's halt/step/reset
// controls, the memory bus and the register file port, then answers on the done handshake.
module dbg_dut_responder #(
    parameter int BITSIZE    = 32,
    parameter int RST_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rstn_i,
    input  logic [7:0]         dbg_cmd_i,
    input  logic [BITSIZE-1:0] dbg_addr_i,
    input  logic [BITSIZE-1:0] dbg_data_i,
    output logic [BITSIZE-1:0] dbg_data_o,
    output logic               dbg_done_o,
    output logic               halt_o,
    output logic               step_o,
    output logic               core_rst_o,
    input  logic               core_halted_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [BITSIZE-1:0] mem_addr_o,
    output logic [BITSIZE-1:0] mem_wdata_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [BITSIZE-1:0] mem_rdata_i,
    output logic               reg_req_o,
    output logic               reg_we_o,
    output logic [4:0]         reg_addr_o,
    output logic [BITSIZE-1:0] reg_wdata_o,
    input  logic [BITSIZE-1:0] reg_rdata_i
);

    localparam logic [7:0] CMD_NOP    = 8'h00;
    localparam logic [7:0] CMD_HALT   = 8'h01;
    localparam logic [7:0] CMD_RESUME = 8'h02;
    localparam logic [7:0] CMD_STEP   = 8'h03;
    localparam logic [7:0] CMD_RESET  = 8'h04;
    localparam logic [7:0] CMD_MEM_RD = 8'h05;
    localparam logic [7:0] CMD_MEM_WR = 8'h06;
    localparam logic [7:0] CMD_REG_RD = 8'h07;
    localparam logic [7:0] CMD_REG_WR = 8'h08;
    localparam logic [7:0] CMD_STATUS = 8'h09;

    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_HALT_WAIT   = 4'd1;
    localparam logic [3:0] S_RES_WAIT    = 4'd2;
    localparam logic [3:0] S_STEP_WAIT   = 4'd3;
    localparam logic [3:0] S_RST         = 4'd4;
    localparam logic [3:0] S_MEM_REQ     = 4'd5;
    localparam logic [3:0] S_MEM_WAIT    = 4'd6;
    localparam logic [3:0] S_REG_ACC     = 4'd7;
    localparam logic [3:0] S_REG_RD_WAIT = 4'd8;
    localparam logic [3:0] S_DONE        = 4'd9;

    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    logic [3:0]         state;
    logic               cmd_vld;
    logic [7:0]         cmd_q;
    logic [BITSIZE-1:0] addr_q;
    logic [BITSIZE-1:0] data_q;
    logic [CNT_W-1:0]   rst_cnt;
    logic               seen_low;

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = data_q;
    assign reg_addr_o  = addr_q[4:0];
    assign reg_wdata_o = data_q;

    // NOTE: every register below is updated with <= so all of them see pre-edge values.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= S_IDLE;
            cmd_vld    <= 1'b0;
            cmd_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rst_cnt    <= '0;
            seen_low   <= 1'b0;
            dbg_data_o <= '0;
            dbg_done_o <= 1'b0;
            halt_o     <= 1'b0;
            step_o     <= 1'b0;
            core_rst_o <= 1'b0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            reg_req_o  <= 1'b0;
            reg_we_o   <= 1'b0;
        end else begin
            // Done lags the DONE state by one cycle, so it also falls one cycle after exit.
            dbg_done_o <= (state == S_DONE);
            step_o     <= 1'b0;
            reg_req_o  <= 1'b0;
            reg_we_o   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!cmd_vld) begin
                        if (dbg_cmd_i != CMD_NOP) begin
                            cmd_q   <= dbg_cmd_i;
                            addr_q  <= dbg_addr_i;
                            data_q  <= dbg_data_i;
                            cmd_vld <= 1'b1;
                        end
                    end else begin
                        // Decode cycle: act on the latched command, debugger inputs are ignored.
                        cmd_vld <= 1'b0;
                        state   <= S_DONE;
                        case (cmd_q)
                            CMD_HALT: begin
                                halt_o <= 1'b1;
                                state  <= S_HALT_WAIT;
                            end
                            CMD_RESUME: begin
                                halt_o <= 1'b0;
                                state  <= S_RES_WAIT;
                            end
                            CMD_STEP: begin
                                if (core_halted_i) begin
                                    step_o   <= 1'b1;
                                    seen_low <= 1'b0;
                                    state    <= S_STEP_WAIT;
                                end else begin
                                    dbg_data_o <= '1;
                                end
                            end
                            CMD_RESET: begin
                                core_rst_o <= 1'b1;
                                rst_cnt    <= CNT_W'(RST_CYCLES - 1);
                                state      <= S_RST;
                            end
                            CMD_MEM_RD, CMD_MEM_WR: begin
                                mem_req_o <= 1'b1;
                                mem_we_o  <= (cmd_q == CMD_MEM_WR);
                                state     <= S_MEM_REQ;
                            end
                            CMD_REG_RD, CMD_REG_WR: begin
                                if (core_halted_i) begin
                                    reg_req_o <= 1'b1;
                                    reg_we_o  <= (cmd_q == CMD_REG_WR);
                                    state     <= S_REG_ACC;
                                end else begin
                                    dbg_data_o <= '1;
                                end
                            end
                            CMD_STATUS: dbg_data_o <= {{(BITSIZE-2){1'b0}}, halt_o, core_halted_i};
                            default:    dbg_data_o <= '1;
                        endcase
                    end
                end
                S_HALT_WAIT: if (core_halted_i) state <= S_DONE;
                S_RES_WAIT:  if (!core_halted_i) state <= S_DONE;
                S_STEP_WAIT: begin
                    // The core must visibly leave halt before its return to halt counts.
                    if (!core_halted_i) seen_low <= 1'b1;
                    if (seen_low && core_halted_i) state <= S_DONE;
                end
                S_RST: begin
                    if (rst_cnt == '0) begin
                        core_rst_o <= 1'b0;
                        state      <= S_DONE;
                    end else begin
                        rst_cnt <= rst_cnt - 1'b1;
                    end
                end
                S_MEM_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        state     <= (cmd_q == CMD_MEM_WR) ? S_DONE : S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_rvalid_i) begin
                        dbg_data_o <= mem_rdata_i;
                        state      <= S_DONE;
                    end
                end
                S_REG_ACC:     state <= (cmd_q == CMD_REG_RD) ? S_REG_RD_WAIT : S_DONE;
                S_REG_RD_WAIT: begin
                    dbg_data_o <= reg_rdata_i;
                    state      <= S_DONE;
                end
                S_DONE:  if (dbg_done_o && (dbg_cmd_i == CMD_NOP)) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_dut_responder.sv
// Directed bench for dbg_dut_responder: walks the debugger handshake through every command
// class with hand-timed core, memory and register-file responses.
module tb_dbg_dut_responder;

    logic        clk;
    logic        rstn_i;
    logic [7:0]  dbg_cmd_i;
    logic [31:0] dbg_addr_i;
    logic [31:0] dbg_data_i;
    logic [31:0] dbg_data_o;
    logic        dbg_done_o;
    logic        halt_o;
    logic        step_o;
    logic        core_rst_o;
    logic        core_halted_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        reg_req_o;
    logic        reg_we_o;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic [31:0] reg_rdata_i;

    int n_assert = 0;
    int n_fail   = 0;

    dbg_dut_responder #(.BITSIZE(32), .RST_CYCLES(4)) dut (
        .clk          (clk),
        .rstn_i       (rstn_i),
        .dbg_cmd_i    (dbg_cmd_i),
        .dbg_addr_i   (dbg_addr_i),
        .dbg_data_i   (dbg_data_i),
        .dbg_data_o   (dbg_data_o),
        .dbg_done_o   (dbg_done_o),
        .halt_o       (halt_o),
        .step_o       (step_o),
        .core_rst_o   (core_rst_o),
        .core_halted_i(core_halted_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .reg_req_o    (reg_req_o),
        .reg_we_o     (reg_we_o),
        .reg_addr_o   (reg_addr_o),
        .reg_wdata_o  (reg_wdata_o),
        .reg_rdata_i  (reg_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge they were updated on.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
        dbg_cmd_i  = cmd;
        dbg_addr_i = addr;
        dbg_data_i = data;
    endtask

    // Ticks until done (bounded); lat counts edges after issue, act flags any control activity.
    task automatic wait_done(input int max_cyc, output int lat, output logic act);
        lat = 0;
        act = 1'b0;
        do begin
            tick();
            lat++;
            act = act | step_o | core_rst_o | mem_req_o | reg_req_o | reg_we_o | halt_o;
        end while (!dbg_done_o && lat < max_cyc);
    endtask

    task automatic finish_cmd(input string tag);
        dbg_cmd_i = 8'h00;
        tick();
        check({tag, " done held"}, 32'(dbg_done_o), 32'd1);
        tick();
        check({tag, " done drop"}, 32'(dbg_done_o), 32'd0);
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] cmd, input logic [31:0] addr,
                           input int exp_lat, input logic [31:0] exp_data, input bit quiet);
        int   lat;
        logic act;
        issue(cmd, addr, 32'h0000_1234);
        wait_done(exp_lat + 8, lat, act);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " data"}, dbg_data_o, exp_data);
        if (quiet) check({tag, " no side effect"}, 32'(act), 32'd0);
        finish_cmd(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         n_hi;
        logic       act;
        logic [7:0] err_cmds [4];

        err_cmds = '{8'h03, 8'h07, 8'h08, 8'h55};
        rstn_i        = 1'b0;
        core_halted_i = 1'b0;
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = 32'hDEAD_DEAD;
        reg_rdata_i   = 32'h0BAD_F00D;
        issue(8'h00, 32'h0, 32'h0);

        // Reset state
        repeat (3) tick();
        check("reset ctl", 32'({halt_o, step_o, core_rst_o, mem_req_o, mem_we_o,
                                 reg_req_o, reg_we_o, dbg_done_o}), 32'd0);
        check("reset data", dbg_data_o, 32'd0);
        rstn_i = 1'b1;
        tick();

        // STATUS with core running: done at N+2, value 0
        run_cmd("status run", 8'h09, 32'h0, 3, 32'h0000_0000, 1'b1);

        // HALT with core acknowledging 3 cycles after the request
        issue(8'h01, 32'h0, 32'h0);
        tick();
        tick();
        check("halt set", 32'(halt_o), 32'd1);
        tick();
        tick();
        check("halt wait", 32'(dbg_done_o), 32'd0);
        core_halted_i = 1'b1;
        wait_done(8, lat, act);
        check("halt latency", 32'(lat), 32'd2);
        finish_cmd("halt");

        run_cmd("status halted", 8'h09, 32'h0, 3, 32'h0000_0003, 1'b0);

        // REG_WR idx 5 (upper address bits ignored); debugger inputs change after latch
        issue(8'h08, 32'hFFFF_FFE5, 32'hCAFE_BABE);
        tick();
        dbg_addr_i = 32'h0;
        dbg_data_i = 32'h0;
        tick();
        check("regwr req/we", 32'({reg_req_o, reg_we_o}), 32'd3);
        check("regwr addr", 32'(reg_addr_o), 32'd5);
        check("regwr wdata", reg_wdata_o, 32'hCAFE_BABE);
        tick();
        check("regwr req pulse", 32'({reg_req_o, reg_we_o}), 32'd0);
        check("regwr not done", 32'(dbg_done_o), 32'd0);
        tick();
        check("regwr done N+3", 32'(dbg_done_o), 32'd1);
        check("regwr data kept", dbg_data_o, 32'h0000_0003);
        finish_cmd("regwr");

        // REG_RD idx 5: rdata valid only in the cycle after reg_req_o
        issue(8'h07, 32'h0000_0005, 32'h0);
        tick();
        tick();
        check("regrd req/we", 32'({reg_req_o, reg_we_o}), 32'd2);
        check("regrd addr", 32'(reg_addr_o), 32'd5);
        tick();
        reg_rdata_i = 32'hCAFE_BABE;
        check("regrd req pulse", 32'(reg_req_o), 32'd0);
        tick();
        reg_rdata_i = 32'h0BAD_F00D;
        check("regrd not done", 32'(dbg_done_o), 32'd0);
        tick();
        check("regrd done N+4", 32'(dbg_done_o), 32'd1);
        check("regrd data", dbg_data_o, 32'hCAFE_BABE);
        finish_cmd("regrd");

        // STEP while halted: one-cycle pulse, core leaves halt for two cycles
        issue(8'h03, 32'h0, 32'h0);
        tick();
        tick();
        check("step pulse", 32'(step_o), 32'd1);
        tick();
        check("step one cycle", 32'(step_o), 32'd0);
        core_halted_i = 1'b0;
        tick();
        tick();
        check("step waits rehalt", 32'(dbg_done_o), 32'd0);
        core_halted_i = 1'b1;
        wait_done(8, lat, act);
        check("step latency", 32'(lat), 32'd2);
        check("step data kept", dbg_data_o, 32'hCAFE_BABE);
        finish_cmd("step");

        // RESET: core_rst_o high exactly RST_CYCLES, halt_o untouched
        issue(8'h04, 32'h0, 32'h0);
        n_hi = 0;
        lat  = 0;
        for (int i = 0; i < 16 && !dbg_done_o; i++) begin
            tick();
            lat++;
            if (core_rst_o) n_hi++;
        end
        check("reset cycles", 32'(n_hi), 32'd4);
        check("reset latency", 32'(lat), 32'd7);
        check("reset halt kept", 32'(halt_o), 32'd1);
        finish_cmd("rst");

        // RESUME: done only after core drops halted
        issue(8'h02, 32'h0, 32'h0);
        tick();
        tick();
        check("resume halt clr", 32'(halt_o), 32'd0);
        tick();
        tick();
        check("resume wait", 32'(dbg_done_o), 32'd0);
        core_halted_i = 1'b0;
        wait_done(8, lat, act);
        check("resume latency", 32'(lat), 32'd2);
        finish_cmd("resume");

        // Running: STEP, REG_RD, REG_WR and an illegal code all error out
        foreach (err_cmds[i]) begin
            run_cmd($sformatf("err %02h", err_cmds[i]), err_cmds[i], 32'h5, 3, 32'hFFFF_FFFF, 1'b1);
            run_cmd("status clr", 8'h09, 32'h0, 3, 32'h0000_0000, 1'b1);
        end

        // MEM_RD 0x1000: gnt in 5th request cycle, rvalid two cycles later
        issue(8'h05, 32'h0000_1000, 32'h0);
        tick();
        tick();
        check("memrd req/we", 32'({mem_req_o, mem_we_o}), 32'd2);
        check("memrd addr", mem_addr_o, 32'h0000_1000);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("memrd req held", 32'(mem_req_o), 32'd1);
        end
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        check("memrd req drop", 32'(mem_req_o), 32'd0);
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1234_5678;
        check("memrd wait", 32'(dbg_done_o), 32'd0);
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'hDEAD_DEAD;
        check("memrd not done", 32'(dbg_done_o), 32'd0);
        tick();
        check("memrd done", 32'(dbg_done_o), 32'd1);
        check("memrd data", dbg_data_o, 32'h1234_5678);
        finish_cmd("memrd");

        // MEM_WR with immediate grant
        issue(8'h06, 32'h0000_2000, 32'hA5A5_A5A5);
        tick();
        tick();
        check("memwr req/we", 32'({mem_req_o, mem_we_o}), 32'd3);
        check("memwr addr", mem_addr_o, 32'h0000_2000);
        check("memwr wdata", mem_wdata_o, 32'hA5A5_A5A5);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        check("memwr req drop", 32'({mem_req_o, dbg_done_o}), 32'd0);
        tick();
        check("memwr done", 32'(dbg_done_o), 32'd1);
        check("memwr data kept", dbg_data_o, 32'h1234_5678);
        finish_cmd("memwr");

        // Halt again, then hit rstn_i in the middle of a MEM_RD wait
        core_halted_i = 1'b1;
        run_cmd("halt2", 8'h01, 32'h0, 4, 32'h1234_5678, 1'b0);
        issue(8'h05, 32'h0000_3000, 32'h0);
        tick();
        tick();
        check("abort req", 32'(mem_req_o), 32'd1);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        check("abort in wait", 32'({mem_req_o, halt_o, dbg_done_o}), 32'd2);
        #2;
        rstn_i = 1'b0;
        #1;
        check("abort ctl", 32'({halt_o, step_o, core_rst_o, mem_req_o, mem_we_o,
                                 reg_req_o, reg_we_o, dbg_done_o}), 32'd0);
        check("abort data", dbg_data_o, 32'd0);
        check("abort addr", mem_addr_o, 32'd0);
        core_halted_i = 1'b0;
        dbg_cmd_i     = 8'h00;
        tick();
        rstn_i = 1'b1;
        tick();
        tick();
        check("abort idle", 32'({mem_req_o, dbg_done_o}), 32'd0);
        run_cmd("status post", 8'h09, 32'h0, 3, 32'h0000_0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
